// File: rtl/sram10t_se_array.sv
// Behavioural array of single-ended 10T SRAM cells with a registered write port and a registered, decoupled read port.
// Only Q is stored because QB is always ~Q. Reads sample the contents from before any same-edge write.
module sram10t_se_array #(
   parameter int unsigned WORDS  = 16,
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [WIDTH-1:0]  wmask,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata,
   output logic              rvalid,
   output logic              collision
);

   logic [WIDTH-1:0] q [WORDS];
   logic [WORDS-1:0] wl_write;
   logic             waddr_ok;
   logic             same_addr;
   logic [WIDTH-1:0] rbl;

   assign waddr_ok  = (32'(waddr) < WORDS);
   assign same_addr = (waddr == raddr);

   // Write wordline decode. Addresses at or above WORDS select no row.
   always_comb begin
      wl_write = '0;
      for (int unsigned w = 0; w < WORDS; w++)
         wl_write[w] = we && (32'(waddr) == w);
   end

   // Read bitline. An unselected or out-of-range row reads as zero.
   always_comb begin
      rbl = '0;
      for (int unsigned w = 0; w < WORDS; w++)
         if (32'(raddr) == w)
            rbl = q[w];
   end

   // Cell storage. Each bit is written only where wmask is set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned w = 0; w < WORDS; w++)
            q[w] <= '0;
      end else begin
         for (int unsigned w = 0; w < WORDS; w++)
            if (wl_write[w])
               q[w] <= (q[w] & ~wmask) | (wdata & wmask);
      end
   end

   // Read port. rbl is sampled before the same-edge write, which gives read-before-write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata     <= '0;
         rvalid    <= 1'b0;
         collision <= 1'b0;
      end else begin
         rvalid    <= re;
         collision <= re && we && waddr_ok && same_addr;
         if (re)
            rdata <= rbl;
      end
   end

endmodule

// File: tb/tb_sram10t_se_array.sv
// Directed scoreboard bench for sram10t_se_array with WORDS=12, so that out-of-range addresses can be exercised.
module tb_sram10t_se_array;

   localparam int unsigned WORDS  = 12;
   localparam int unsigned WIDTH  = 8;
   localparam int unsigned ADDR_W = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              we = 1'b0;
   logic [ADDR_W-1:0] waddr = '0;
   logic [WIDTH-1:0]  wdata = '0;
   logic [WIDTH-1:0]  wmask = '0;
   logic              re = 1'b0;
   logic [ADDR_W-1:0] raddr = '0;
   logic [WIDTH-1:0]  rdata;
   logic              rvalid;
   logic              collision;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic             coll;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   sram10t_se_array #(.WORDS(WORDS), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wmask(wmask),
      .re(re), .raddr(raddr), .rdata(rdata), .rvalid(rvalid), .collision(collision)
   );

   always #5 clk = ~clk;

   // Monitor: every valid read result is checked against the oldest queued expectation.
   always @(negedge clk) begin
      if (!rst && rvalid) begin
         exp_t e;
         n_vec++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_rvalid: got rdata=%h collision=%b, required no valid read", rdata, collision);
         end else begin
            e = sb.pop_front();
            if (rdata !== e.data || collision !== e.coll) begin
               n_err++;
               $display("FAIL read_result: got rdata=%h collision=%b, required rdata=%h collision=%b",
                        rdata, collision, e.data, e.coll);
            end
         end
      end
   end

   task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // Drives one cycle starting at posedge+1 and returns at the next posedge+1.
   task automatic step(input logic w, input logic [ADDR_W-1:0] wa, input logic [WIDTH-1:0] wd,
                       input logic [WIDTH-1:0] wm, input logic r, input logic [ADDR_W-1:0] ra,
                       input logic [WIDTH-1:0] exp_d, input logic exp_c);
      we = w; waddr = wa; wdata = wd; wmask = wm; re = r; raddr = ra;
      if (r) sb.push_back('{data: exp_d, coll: exp_c});
      @(posedge clk); #1;
      we = 1'b0; re = 1'b0;
   endtask

   task automatic wr(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] m);
      step(1'b1, a, d, m, 1'b0, '0, '0, 1'b0);
   endtask

   task automatic rd(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] exp_d, input logic exp_c);
      step(1'b0, '0, '0, '0, 1'b1, a, exp_d, exp_c);
   endtask

   task automatic idle();
      step(1'b0, '0, '0, '0, 1'b0, '0, '0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      #17 rst = 1'b0;
      @(posedge clk); #1;
      idle();

      // Asynchronous reset asserted in the middle of a cycle.
      @(posedge clk); #3 rst = 1'b1;
      #1;
      check("rst_rdata", rdata, 8'h00);
      check("rst_rvalid", {7'b0, rvalid}, 8'h00);
      check("rst_collision", {7'b0, collision}, 8'h00);
      @(posedge clk); #3 rst = 1'b0;
      @(posedge clk); #1;
      check("pre_read_rvalid", {7'b0, rvalid}, 8'h00);
      rd(4'd3, 8'h00, 1'b0);

      // Basic write and read.
      wr(4'd5, 8'hA5, 8'hFF);
      rd(4'd5, 8'hA5, 1'b0);
      wr(4'd5, 8'h5A, 8'hFF);
      rd(4'd5, 8'h5A, 1'b0);

      // Masked write.
      wr(4'd2, 8'hFF, 8'hFF);
      wr(4'd2, 8'h00, 8'h0F);
      rd(4'd2, 8'hF0, 1'b0);

      // Same-address collision returns the old data, then the new data.
      wr(4'd7, 8'h11, 8'hFF);
      step(1'b1, 4'd7, 8'h22, 8'hFF, 1'b1, 4'd7, 8'h11, 1'b1);
      rd(4'd7, 8'h22, 1'b0);

      // Different addresses are independent.
      step(1'b1, 4'd3, 8'h3C, 8'hFF, 1'b1, 4'd5, 8'h5A, 1'b0);
      rd(4'd3, 8'h3C, 1'b0);

      // Out-of-range accesses with WORDS=12.
      wr(4'd13, 8'h33, 8'hFF);
      rd(4'd13, 8'h00, 1'b0);
      rd(4'd1, 8'h00, 1'b0);
      rd(4'd5, 8'h5A, 1'b0);
      wr(4'd12, 8'h44, 8'hFF);
      rd(4'd12, 8'h00, 1'b0);
      rd(4'd0, 8'h00, 1'b0);
      step(1'b1, 4'd13, 8'h66, 8'hFF, 1'b1, 4'd13, 8'h00, 1'b0);
      wr(4'd11, 8'h77, 8'hFF);
      rd(4'd11, 8'h77, 1'b0);
      rd(4'd15, 8'h00, 1'b0);
      rd(4'd11, 8'h77, 1'b0);

      // rdata holds its value when re is low.
      idle();
      check("hold_rvalid", {7'b0, rvalid}, 8'h00);
      check("hold_rdata", rdata, 8'h77);
      check("hold_collision", {7'b0, collision}, 8'h00);
      wr(4'd11, 8'h00, 8'h00);
      rd(4'd11, 8'h77, 1'b0);

      // Reset during an in-flight read discards the read and clears the cells.
      wr(4'd4, 8'hC3, 8'hFF);
      rd(4'd4, 8'hC3, 1'b0);
      idle();
      re = 1'b1; raddr = 4'd4;
      #2 rst = 1'b1;
      #1;
      check("midop_rdata", rdata, 8'h00);
      check("midop_rvalid", {7'b0, rvalid}, 8'h00);
      @(posedge clk); #3;
      check("held_rst_rvalid", {7'b0, rvalid}, 8'h00);
      re = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
      rd(4'd4, 8'h00, 1'b0);

      idle();
      idle();
      idle();
      check("scoreboard_drained", 8'(sb.size()), 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sram10t_se_array.md
Name: sram10t_se_array

Overview:
- Synchronous behavioural model of a small array of single-ended 10T SRAM bit cells.
- Each bit cell has a cross-coupled storage pair Q/QB, a single-ended write path and a decoupled, gated single-ended read path.
- Wraps the cells with registered write and read ports, reset and collision handling.
- Used as a register-file/scratchpad macro model wherever the team instantiates the 10T cell as an array.

Parameters:
- WORDS, 16, number of addressable words; need not be a power of two.
- WIDTH, 8, bits per word (one 10T cell per bit).
- ADDR_W, 4, address width; must satisfy 2**ADDR_W >= WORDS.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- we  input  1  write wordline enable.
- waddr  input  ADDR_W  write address.
- wdata  input  WIDTH  single-ended write data; the QB node is driven with ~wdata.
- wmask  input  WIDTH  per-bit write enable; a bit is written only where wmask=1.
- re  input  1  read wordline enable.
- raddr  input  ADDR_W  read address.
- rdata  output  WIDTH  registered single-ended read bitline value.
- rvalid  output  1  high for one cycle when rdata carries a fresh read.
- collision  output  1  registered flag; same-address read and write occurred in the same cycle.

Behaviour:
- Storage
  - Each cell holds Q with QB = ~Q at all times.
  - The model keeps Q only.
- Reset
  - Asserting rst clears immediately, independent of clk: every cell Q=0, rdata=0, rvalid=0, collision=0.
  - State stays cleared while rst is high.
  - Operation resumes on the first rising edge after rst deasserts.
  - If reset hits mid-operation, any write or read in flight that cycle is discarded.
- Write
  - On a rising edge with we=1 and waddr<WORDS, every bit i with wmask[i]=1 takes Q=wdata[i].
  - Masked bits keep their value.
  - Single-cycle; the new value is visible to a read issued on the next edge.
  - A write with waddr>=WORDS is ignored; no cell changes.
- Read
  - On a rising edge with re=1: rdata <= Q of word raddr and rvalid <= 1.
  - Latency: 1 cycle.
  - re=1 with raddr>=WORDS: rdata <= 0 and rvalid <= 1.
  - re=0: rvalid <= 0 and rdata holds its previous value.
  - Reads never modify cell contents (decoupled read path, no read disturb).
- Simultaneous read and write, same in-range address
  - Read-before-write: rdata returns the pre-write contents.
  - The write still completes.
  - collision <= 1 for that cycle's result; otherwise collision <= 0.
- Simultaneous read and write, different addresses: fully independent.
- No handshake back-pressure; a new request is accepted every cycle.
- No X propagation from unwritten cells, because reset defines all of them.

Test Plan:
- Reset then read: assert rst asynchronously mid-cycle, release, then re=1, raddr=3 -> rdata=0x00 and rvalid=1 one cycle later; rvalid=0 before that.
- Basic write/read: we=1, waddr=5, wdata=0xA5, wmask=0xFF; next cycle re=1, raddr=5 -> rdata=0xA5 after 1 cycle. Repeat with 0x5A -> 0x5A.
- Masked write: word 2 = 0xFF, then write wdata=0x00, wmask=0x0F -> read of word 2 returns 0xF0.
- Collision: word 7 = 0x11; same cycle we=1, waddr=7, wdata=0x22 and re=1, raddr=7 -> rdata=0x11, collision=1; following read of 7 -> 0x22, collision=0.
- Out of range with WORDS=12: write 0x33 to address 13 -> no cell changes; read address 13 -> rdata=0x00, rvalid=1.
- Reset mid-operation: write word 4 = 0xC3, then assert rst during a cycle with re=1, raddr=4 -> rdata=0, rvalid=0 immediately; after release, read of 4 -> 0x00.
